// File: rtl/pipelined_controller_param_if.sv
// pipelined_controller_param_if
//   Bundles the instruction handshake and the result/flags outputs of
//   pipelined_controller_param.
//
// Handshake: an instruction transfers on a sys_clk rising edge where
// instr_valid and instr_ready are both high. The source holds instr_valid
// and the instruction fields stable until that edge. instr_ready never
// depends combinationally on instr_valid.
//
// Signals:
//   instr_valid  source -> ctrl  instruction fields valid this cycle
//   instr_ready  ctrl -> source  controller can accept this cycle
//   opcode_in    source -> ctrl  operation
//   s1_in/s2_in  source -> ctrl  source register addresses
//   dest_in      source -> ctrl  destination register address
//   ime_data_in  source -> ctrl  immediate
//   result_out   ctrl -> sink    Execute-stage result
//   result_valid ctrl -> sink    one pulse per register-writing instruction
//   flags_out    ctrl -> sink    {negative, carry, zero}, held between updates
//   illegal_op   ctrl -> sink    pulse when an unknown opcode leaves Execute
//
// Modports: master = instruction source / result sink, slave = controller.
interface pipelined_controller_param_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int OPCODE_W   = 5
);
  logic                  instr_valid;
  logic                  instr_ready;
  logic [OPCODE_W-1:0]   opcode_in;
  logic [REG_ADDR_W-1:0] s1_in;
  logic [REG_ADDR_W-1:0] s2_in;
  logic [REG_ADDR_W-1:0] dest_in;
  logic [DATA_W-1:0]     ime_data_in;
  logic [DATA_W-1:0]     result_out;
  logic                  result_valid;
  logic [2:0]            flags_out;
  logic                  illegal_op;

  modport master (
    output instr_valid, opcode_in, s1_in, s2_in, dest_in, ime_data_in,
    input  instr_ready, result_out, result_valid, flags_out, illegal_op
  );

  modport slave (
    input  instr_valid, opcode_in, s1_in, s2_in, dest_in, ime_data_in,
    output instr_ready, result_out, result_valid, flags_out, illegal_op
  );
endinterface

// File: rtl/pipelined_controller_param.sv
// pipelined_controller_param
//   Four-stage pipelined controller: Fetch -> Decode/operand-read ->
//   Execute -> Writeback, with an internal register file and ALU.
//   An instruction transferred at edge k produces result_valid for the
//   cycle after edge k+2 and is written to the register file at edge k+3.
//
// Ports:
//   sys_clk  sole clock, rising edge
//   reset    synchronous, active-high; flushes the pipeline and clears
//            the register file
//   bus      pipelined_controller_param_if.slave (handshake + results)
//
// Build option:
//   FORWARDING_EN defined   -> operands are forwarded from the ID-stage ALU
//                              output and the EX register; never stalls.
//   FORWARDING_EN undefined -> read-after-write hazards stall Fetch until
//                              the producer has been written back.
module pipelined_controller_param #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int OPCODE_W   = 5
) (
  input logic                         sys_clk,
  input logic                         reset,
  pipelined_controller_param_if.slave bus
);

  localparam int NREGS = 2 ** REG_ADDR_W;
  localparam int SH_W  = $clog2(DATA_W);

  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_NOT  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_SHL  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_SHR  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_MOV  = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_CMP  = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_NOP  = '1;

  // Opcodes 0..10 write a register; 0..11 update flags.
  function automatic logic op_writes(input logic [OPCODE_W-1:0] op);
    return op <= OP_MOV;
  endfunction

  function automatic logic op_flags(input logic [OPCODE_W-1:0] op);
    return op <= OP_CMP;
  endfunction

  function automatic logic op_illegal(input logic [OPCODE_W-1:0] op);
    return !(op <= OP_CMP) && (op != OP_NOP);
  endfunction

  // Register file
  logic [DATA_W-1:0] regs [NREGS];

  // F stage
  logic                  f_valid;
  logic [OPCODE_W-1:0]   f_op;
  logic [REG_ADDR_W-1:0] f_s1, f_s2, f_dest;
  logic [DATA_W-1:0]     f_imm;

  // ID stage
  logic                  id_valid;
  logic [OPCODE_W-1:0]   id_op;
  logic [REG_ADDR_W-1:0] id_dest;
  logic [DATA_W-1:0]     id_imm, id_a, id_b;
  logic                  id_wr;

  // EX stage (ex_wr doubles as result_valid)
  logic                  ex_wr;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic [DATA_W-1:0]     ex_result;
  logic [2:0]            flags_q;
  logic                  illegal_q;

  logic                  stall;
  logic                  take;
  logic [DATA_W-1:0]     op_a, op_b;

  assign id_wr           = id_valid && op_writes(id_op);
  assign bus.instr_ready = !reset && !stall;
  assign take            = bus.instr_valid && bus.instr_ready;

  // ALU on the ID register
  logic [DATA_W:0]   sum_w, diff_w;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic [2:0]        alu_flags;

  assign sum_w  = {1'b0, id_a} + {1'b0, (id_op == OP_ADDI) ? id_imm : id_b};
  // Top bit of the widened difference is the borrow (s1 < s2 unsigned).
  assign diff_w = {1'b0, id_a} - {1'b0, id_b};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (id_op)
      OP_ADD, OP_ADDI: {alu_c, alu_res} = sum_w;
      OP_SUB, OP_CMP:  {alu_c, alu_res} = diff_w;
      OP_AND:          alu_res = id_a & id_b;
      OP_OR:           alu_res = id_a | id_b;
      OP_XOR:          alu_res = id_a ^ id_b;
      OP_NOT:          alu_res = ~id_a;
      OP_SHL:          alu_res = id_a << id_b[SH_W-1:0];
      OP_SHR:          alu_res = id_a >> id_b[SH_W-1:0];
      OP_LDI:          alu_res = id_imm;
      OP_MOV:          alu_res = id_a;
      default:         alu_res = '0;
    endcase
  end

  assign alu_flags = {alu_res[DATA_W-1], alu_c, (alu_res == '0)};

`ifdef FORWARDING_EN
  // Youngest producer wins: ID-stage ALU output, then EX register, then RF.
  // The EX register is written to the RF on the same edge it is forwarded.
  always_comb begin
    stall = 1'b0;
    if (id_wr && id_dest == f_s1)      op_a = alu_res;
    else if (ex_wr && ex_dest == f_s1) op_a = ex_result;
    else                               op_a = regs[f_s1];
    if (id_wr && id_dest == f_s2)      op_b = alu_res;
    else if (ex_wr && ex_dest == f_s2) op_b = ex_result;
    else                               op_b = regs[f_s2];
  end
`else
  // Only sources an opcode actually reads may cause a stall.
  function automatic logic uses_s1(input logic [OPCODE_W-1:0] op);
    return (op <= OP_CMP) && (op != OP_LDI);
  endfunction

  function automatic logic uses_s2(input logic [OPCODE_W-1:0] op);
    return (op <= OP_XOR) || (op == OP_SHL) || (op == OP_SHR) || (op == OP_CMP);
  endfunction

  logic hit_s1, hit_s2;

  // A producer in EX is written at the same edge F would read, so F waits
  // until the RF holds the value: 2 cycles behind ID, 1 behind EX.
  always_comb begin
    op_a   = regs[f_s1];
    op_b   = regs[f_s2];
    hit_s1 = (id_wr && id_dest == f_s1) || (ex_wr && ex_dest == f_s1);
    hit_s2 = (id_wr && id_dest == f_s2) || (ex_wr && ex_dest == f_s2);
    stall  = f_valid && ((uses_s1(f_op) && hit_s1) || (uses_s2(f_op) && hit_s2));
  end
`endif

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      f_valid   <= 1'b0;
      f_op      <= '0;
      f_s1      <= '0;
      f_s2      <= '0;
      f_dest    <= '0;
      f_imm     <= '0;
      id_valid  <= 1'b0;
      id_op     <= '0;
      id_dest   <= '0;
      id_imm    <= '0;
      id_a      <= '0;
      id_b      <= '0;
      ex_wr     <= 1'b0;
      ex_dest   <= '0;
      ex_result <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      // WB
      if (ex_wr) regs[ex_dest] <= ex_result;

      // F: hold while stalled, otherwise refill (or empty) every cycle
      if (!stall) begin
        f_valid <= take;
        if (take) begin
          f_op   <= bus.opcode_in;
          f_s1   <= bus.s1_in;
          f_s2   <= bus.s2_in;
          f_dest <= bus.dest_in;
          f_imm  <= bus.ime_data_in;
        end
      end

      // ID: a stall inserts a bubble
      id_valid <= f_valid && !stall;
      if (f_valid && !stall) begin
        id_op   <= f_op;
        id_dest <= f_dest;
        id_imm  <= f_imm;
        id_a    <= op_a;
        id_b    <= op_b;
      end

      // EX
      ex_wr <= id_wr;
      if (id_wr) begin
        ex_result <= alu_res;
        ex_dest   <= id_dest;
      end
      if (id_valid && op_flags(id_op)) flags_q <= alu_flags;
      illegal_q <= id_valid && op_illegal(id_op);
    end
  end

  assign bus.result_out   = ex_result;
  assign bus.result_valid = ex_wr;
  assign bus.flags_out    = flags_q;
  assign bus.illegal_op   = illegal_q;

endmodule
